// File: rtl/secuenciador_pc_pkg.sv
// Shared defaults and next-PC select encoding for the program-counter unit.
package pc_defs;

  localparam int unsigned ANCHO_DEF     = 64;
  localparam int unsigned PASO_DEF      = 4;
  localparam int unsigned LOG2_PASO_DEF = 2;

  localparam logic [63:0] VECTOR_RESET_DEF = 64'h0;

  typedef enum logic [1:0] {
    SEL_ABS  = 2'd0,
    SEL_REL  = 2'd1,
    SEL_SEQ  = 2'd2,
    SEL_HOLD = 2'd3
  } sel_pc_e;

endpackage

// File: rtl/secuenciador_pc_sumador.sv
// Plain modulo-2^ANCHO adder; used for both PC+PASO and PC+offset.
module sumador_pc #(
  parameter int unsigned ANCHO = pc_defs::ANCHO_DEF
) (
  input  logic [ANCHO-1:0] i_a,
  input  logic [ANCHO-1:0] i_b,
  output logic [ANCHO-1:0] o_suma
);

  assign o_suma = i_a + i_b;

endmodule

// File: rtl/secuenciador_pc.sv
// Program-counter unit: next-PC selection, fetch-valid flag, sticky
// misalignment flag and saturating fetch counter.
module secuenciador_pc
  import pc_defs::*;
#(
  parameter int unsigned            ANCHO        = ANCHO_DEF,
  parameter int unsigned            PASO         = PASO_DEF,
  parameter int unsigned            LOG2_PASO    = LOG2_PASO_DEF,
  parameter int unsigned            ANCHO_DESP   = 26,
  parameter logic [ANCHO-1:0]       VECTOR_RESET = ANCHO'(VECTOR_RESET_DEF),
  parameter int unsigned            ANCHO_CONT   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  im_listo,
  input  logic                  bloqueo,
  input  logic                  salto_rel,
  input  logic [ANCHO_DESP-1:0] bus_desplazamiento,
  input  logic                  salto_abs,
  input  logic [ANCHO-1:0]      bus_destino_reg,
  output logic [ANCHO-1:0]      bus_direccion_im,
  output logic [ANCHO-1:0]      bus_pc_next,
  output logic                  valido,
  output logic                  error_alineacion,
  output logic [ANCHO_CONT-1:0] contador_fetch
);

  localparam logic [ANCHO-1:0] PasoVec    = ANCHO'(PASO);
  localparam logic [ANCHO-1:0] MascaraLsb = ANCHO'(PASO - 1);

  logic [ANCHO-1:0]      r_pc;
  logic                  r_valido;
  logic                  r_error;
  logic [ANCHO_CONT-1:0] r_cont;

  logic                  w_avanzar;
  logic [ANCHO-1:0]      w_pc_mas_paso;
  logic [ANCHO-1:0]      w_pc_rel;
  logic signed [ANCHO-1:0] w_desp_ext;
  logic [ANCHO-1:0]      w_desp_bytes;
  logic [ANCHO-1:0]      w_destino_alin;
  logic                  w_desalineado;
  sel_pc_e               w_sel;
  logic [ANCHO-1:0]      w_pc_d;

  assign w_avanzar = r_valido & im_listo & ~bloqueo;

  // Offset is in instructions: sign-extend first, then scale to bytes.
  assign w_desp_ext   = ANCHO'($signed(bus_desplazamiento));
  assign w_desp_bytes = w_desp_ext << LOG2_PASO;

  assign w_destino_alin = bus_destino_reg & ~MascaraLsb;
  assign w_desalineado  = |(bus_destino_reg & MascaraLsb);

  sumador_pc #(
    .ANCHO (ANCHO)
  ) u_sumador_seq (
    .i_a    (r_pc),
    .i_b    (PasoVec),
    .o_suma (w_pc_mas_paso)
  );

  sumador_pc #(
    .ANCHO (ANCHO)
  ) u_sumador_rel (
    .i_a    (r_pc),
    .i_b    (w_desp_bytes),
    .o_suma (w_pc_rel)
  );

  always_comb begin
    w_sel = SEL_HOLD;
    if (salto_abs) begin
      w_sel = SEL_ABS;
    end else if (salto_rel) begin
      w_sel = SEL_REL;
    end else if (w_avanzar) begin
      w_sel = SEL_SEQ;
    end
  end

  always_comb begin
    w_pc_d = r_pc;
    unique case (w_sel)
      SEL_ABS:  w_pc_d = w_destino_alin;
      SEL_REL:  w_pc_d = w_pc_rel;
      SEL_SEQ:  w_pc_d = w_pc_mas_paso;
      SEL_HOLD: w_pc_d = r_pc;
      default:  w_pc_d = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc     <= VECTOR_RESET;
      r_valido <= 1'b0;
      r_error  <= 1'b0;
      r_cont   <= '0;
    end else if (!r_valido) begin
      // First edge out of reset only arms the fetch; VECTOR_RESET is fetched first.
      r_valido <= 1'b1;
    end else begin
      r_pc <= w_pc_d;
      if (salto_abs && w_desalineado) begin
        r_error <= 1'b1;
      end
      if (w_avanzar && (r_cont != '1)) begin
        r_cont <= r_cont + ANCHO_CONT'(1);
      end
    end
  end

  assign bus_direccion_im = r_pc;
  assign bus_pc_next      = w_pc_mas_paso;
  assign valido           = r_valido;
  assign error_alineacion = r_error;
  assign contador_fetch   = r_cont;

endmodule

// File: tb/tb_secuenciador_pc.sv
// Self-checking bench for secuenciador_pc: directed scenarios plus random
// stimulus against a behavioural next-PC model.
module tb_secuenciador_pc;

  localparam logic [63:0] VR = 64'h400;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        im_listo;
  logic        bloqueo;
  logic        salto_rel;
  logic [25:0] bus_desplazamiento;
  logic        salto_abs;
  logic [63:0] bus_destino_reg;
  logic [63:0] bus_direccion_im;
  logic [63:0] bus_pc_next;
  logic        valido;
  logic        error_alineacion;
  logic [31:0] contador_fetch;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_pc  = '0;
  bit          m_val = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_cnt = '0;

  always #5 clk = ~clk;

  secuenciador_pc #(
    .ANCHO        (64),
    .PASO         (4),
    .LOG2_PASO    (2),
    .ANCHO_DESP   (26),
    .VECTOR_RESET (VR),
    .ANCHO_CONT   (32)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .im_listo           (im_listo),
    .bloqueo            (bloqueo),
    .salto_rel          (salto_rel),
    .bus_desplazamiento (bus_desplazamiento),
    .salto_abs          (salto_abs),
    .bus_destino_reg    (bus_destino_reg),
    .bus_direccion_im   (bus_direccion_im),
    .bus_pc_next        (bus_pc_next),
    .valido             (valido),
    .error_alineacion   (error_alineacion),
    .contador_fetch     (contador_fetch)
  );

  // Drive one cycle of inputs, advance the model, and land on the falling edge.
  task automatic tick(input logic rn, input logic im, input logic blq, input logic rel,
                      input logic [25:0] desp, input logic abs, input logic [63:0] dest);
    logic signed [63:0] ext;
    bit adv;
    reset_n = rn; im_listo = im; bloqueo = blq; salto_rel = rel;
    bus_desplazamiento = desp; salto_abs = abs; bus_destino_reg = dest;
    if (!rn) begin
      m_pc = VR; m_val = 1'b0; m_err = 1'b0; m_cnt = '0;
    end else if (!m_val) begin
      m_val = 1'b1;
    end else begin
      adv = im && !blq;
      ext = $signed(desp);
      if (abs) begin
        m_pc = dest - (dest % 64'd4);
        if ((dest % 64'd4) != 0) m_err = 1'b1;
      end else if (rel) begin
        m_pc = m_pc + ext * 64'sd4;
      end else if (adv) begin
        m_pc = m_pc + 64'd4;
      end
      if (adv && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [63:0] exp_pc [4] = '{64'h400, 64'h404, 64'h408, 64'h40C};
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    n_checks++;
    if (bus_direccion_im !== 64'h400 || valido !== 1'b0 || contador_fetch !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h valido=%b cnt=%0d, required pc=400 valido=0 cnt=0",
               bus_direccion_im, valido, contador_fetch);
    end
    n_checks++;
    if (bus_pc_next !== 64'h404) begin
      n_fail++;
      $display("FAIL reset_pc_next: got %h required 404", bus_pc_next);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
      n_checks++;
      if (bus_direccion_im !== exp_pc[i] || valido !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_fetch[%0d]: pc=%h valido=%b, required pc=%h valido=1",
                 i, bus_direccion_im, valido, exp_pc[i]);
      end
    end
    n_checks++;
    if (contador_fetch !== 32'd3) begin
      n_fail++;
      $display("FAIL seq_count: got %0d required 3", contador_fetch);
    end
  endtask

  task automatic test_bloqueo;
    logic [31:0] cnt0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 64'h1000);
    cnt0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
      n_checks++;
      if (bus_direccion_im !== 64'h1000 || bus_pc_next !== 64'h1004 ||
          contador_fetch !== cnt0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: pc=%h next=%h cnt=%0d, required 1000 1004 %0d",
                 i, bus_direccion_im, bus_pc_next, contador_fetch, cnt0);
      end
    end
  endtask

  task automatic test_rel_neg;
    tick(1'b1, 1'b1, 1'b1, 1'b1, 26'h3FFFFFC, 1'b0, '0);
    n_checks++;
    if (bus_direccion_im !== 64'h0FF0) begin
      n_fail++;
      $display("FAIL rel_neg: got %h required 0ff0", bus_direccion_im);
    end
  endtask

  task automatic test_rel_wrap;
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 64'h20);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 26'h3FFFFF0, 1'b0, '0);
    n_checks++;
    if (bus_direccion_im !== 64'hFFFF_FFFF_FFFF_FFE0 || error_alineacion !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_wrap: pc=%h err=%b, required ffffffffffffffe0 err=0",
               bus_direccion_im, error_alineacion);
    end
  endtask

  task automatic test_abs_sticky;
    tick(1'b1, 1'b1, 1'b0, 1'b1, 26'h10, 1'b1, 64'h2003);
    n_checks++;
    if (bus_direccion_im !== 64'h2000 || error_alineacion !== 1'b1) begin
      n_fail++;
      $display("FAIL abs_misaligned: pc=%h err=%b, required 2000 err=1",
               bus_direccion_im, error_alineacion);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 64'h3000);
    tick(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    n_checks++;
    if (bus_direccion_im !== 64'h3004 || error_alineacion !== 1'b1) begin
      n_fail++;
      $display("FAIL abs_sticky: pc=%h err=%b, required 3004 err=1",
               bus_direccion_im, error_alineacion);
    end
  endtask

  task automatic test_wrap_reset;
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    n_checks++;
    if (bus_direccion_im !== 64'h0 || bus_pc_next !== 64'h4) begin
      n_fail++;
      $display("FAIL seq_wrap: pc=%h next=%h, required 0 4", bus_direccion_im, bus_pc_next);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 64'h8888);
    n_checks++;
    if (bus_direccion_im !== VR || valido !== 1'b0 || contador_fetch !== 32'd0 ||
        error_alineacion !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_over_jump: pc=%h valido=%b cnt=%0d err=%b, required 400 0 0 0",
               bus_direccion_im, valido, contador_fetch, error_alineacion);
    end
  endtask

  task automatic test_random;
    logic        rn, im, blq, rel, abs;
    logic [25:0] desp;
    logic [63:0] dest;
    for (int i = 0; i < 300; i++) begin
      rn   = ($urandom_range(0, 39) != 0);
      im   = ($urandom_range(0, 3) != 0);
      blq  = ($urandom_range(0, 3) == 0);
      rel  = ($urandom_range(0, 5) == 0);
      abs  = ($urandom_range(0, 7) == 0);
      desp = 26'($urandom);
      dest = {32'($urandom), 32'($urandom)};
      tick(rn, im, blq, rel, desp, abs, dest);
      n_checks++;
      if (bus_direccion_im !== m_pc || bus_pc_next !== m_pc + 64'd4 || valido !== m_val ||
          error_alineacion !== m_err || contador_fetch !== m_cnt) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%h next=%h v=%b e=%b c=%0d, required %h %h %b %b %0d",
                 i, bus_direccion_im, bus_pc_next, valido, error_alineacion, contador_fetch,
                 m_pc, m_pc + 64'd4, m_val, m_err, m_cnt);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; im_listo = 1'b0; bloqueo = 1'b0; salto_rel = 1'b0;
    bus_desplazamiento = '0; salto_abs = 1'b0; bus_destino_reg = '0;
    test_reset();
    test_bloqueo();
    test_rel_neg();
    test_rel_wrap();
    test_abs_sticky();
    test_wrap_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
